// File: rtl/load_store_unit.sv
// Load/store unit between execute and data memory: decodes RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW,
// drives a word-wide memory and splits accesses that straddle a 4-byte boundary into two words.
module load_store_unit #(
    parameter logic [31:0] DATA_SEG_BEGIN = 32'h1000,
    parameter logic [31:0] DATA_SEG_SIZE  = 32'h100000,
    parameter bit          SPLIT_EN       = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic [31:0] addr_dmem_ram_o,
    output logic [31:0] wr_data_dmem_ram_o,
    output logic [3:0]  wr_strb_dmem_ram_o,
    output logic        wr_en_dmem_ram_o,
    input  logic [31:0] read_data_dmem_ram_i
);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    localparam logic [32:0] SEG_END = {1'b0, DATA_SEG_BEGIN} + {1'b0, DATA_SEG_SIZE};

    state_t      state_q, state_d;
    logic [31:0] addr_q, wdata_q, word0_q, word1_q;
    logic [2:0]  funct3_q;
    logic        we_q, err_q, cross_q;

    logic [2:0]  in_size;
    logic [3:0]  in_span;
    logic [31:0] in_last;
    logic        in_cross, in_f3_ok, in_seg_ok, in_err;

    logic [1:0]  off;
    logic [7:0]  m8;
    logic [63:0] wdata64;
    logic [31:0] ld32, ld_ext;

    // Request decode on the raw inputs, used only on the accepting edge.
    always_comb begin
        case (req_funct3_i[1:0])
            2'd0:    in_size = 3'd1;
            2'd1:    in_size = 3'd2;
            default: in_size = 3'd4;
        endcase
        in_span   = {2'b00, req_addr_i[1:0]} + {1'b0, in_size};
        in_cross  = (in_span > 4'd4);
        in_f3_ok  = req_we_i ? (req_funct3_i inside {3'd0, 3'd1, 3'd2})
                             : (req_funct3_i inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        in_last   = req_addr_i + {29'd0, in_size} - 32'd1;
        // Touched bytes are contiguous, so checking both ends (and no wrap) covers all of them.
        in_seg_ok = (in_last >= req_addr_i) && (req_addr_i >= DATA_SEG_BEGIN) &&
                    ({1'b0, in_last} < SEG_END);
        in_err    = !in_f3_ok || !in_seg_ok || (in_cross && !SPLIT_EN);
    end

    // Lane placement and extraction for the latched request.
    always_comb begin
        off = addr_q[1:0];
        case (funct3_q[1:0])
            2'd0:    m8 = 8'h01 << off;
            2'd1:    m8 = 8'h03 << off;
            default: m8 = 8'h0F << off;
        endcase
        wdata64 = {32'd0, wdata_q} << {off, 3'b000};
        ld32    = 32'({word1_q, word0_q} >> {off, 3'b000});
        case (funct3_q)
            3'd0:    ld_ext = {{24{ld32[7]}}, ld32[7:0]};
            3'd1:    ld_ext = {{16{ld32[15]}}, ld32[15:0]};
            3'd4:    ld_ext = {24'd0, ld32[7:0]};
            3'd5:    ld_ext = {16'd0, ld32[15:0]};
            default: ld_ext = ld32;
        endcase
    end

    // NOTE: every output and the next state get a default first, so no path can infer a latch.
    always_comb begin
        state_d            = state_q;
        req_ready_o        = 1'b0;
        resp_valid_o       = 1'b0;
        resp_rdata_o       = 32'd0;
        resp_err_o         = 1'b0;
        addr_dmem_ram_o    = 32'd0;
        wr_data_dmem_ram_o = 32'd0;
        wr_strb_dmem_ram_o = 4'd0;
        wr_en_dmem_ram_o   = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) state_d = in_err ? RESP : ACC0;
            end
            ACC0: begin
                addr_dmem_ram_o = {addr_q[31:2], 2'b00};
                if (we_q) begin
                    wr_strb_dmem_ram_o = m8[3:0];
                    wr_data_dmem_ram_o = wdata64[31:0];
                    wr_en_dmem_ram_o   = 1'b1;
                end
                state_d = cross_q ? ACC1 : RESP;
            end
            ACC1: begin
                addr_dmem_ram_o = {addr_q[31:2], 2'b00} + 32'd4;
                if (we_q) begin
                    wr_strb_dmem_ram_o = m8[7:4];
                    wr_data_dmem_ram_o = wdata64[63:32];
                    wr_en_dmem_ram_o   = 1'b1;
                end
                state_d = RESP;
            end
            RESP: begin
                resp_valid_o = 1'b1;
                resp_err_o   = err_q;
                resp_rdata_o = (we_q || err_q) ? 32'd0 : ld_ext;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: all state uses non-blocking assignments; reset is synchronous, so it lives inside the clocked branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            funct3_q <= 3'd0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            cross_q  <= 1'b0;
            word0_q  <= 32'd0;
            word1_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_valid_i) begin
                addr_q   <= req_addr_i;
                wdata_q  <= req_wdata_i;
                funct3_q <= req_funct3_i;
                we_q     <= req_we_i;
                err_q    <= in_err;
                cross_q  <= in_cross;
            end
            if (state_q == ACC0 && !we_q) word0_q <= read_data_dmem_ram_i;
            if (state_q == ACC1 && !we_q) word1_q <= read_data_dmem_ram_i;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a small word memory model, split and non-split instances,
// hand-computed expected bus values, load data, latencies and error cases.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, ns_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;

    logic        ready, resp_valid, resp_err, wr_en;
    logic [31:0] resp_rdata, mem_addr, wr_data, rd_data;
    logic [3:0]  wr_strb;

    logic        ns_ready, ns_resp_valid, ns_resp_err, ns_wr_en;
    logic [31:0] ns_resp_rdata, ns_mem_addr, ns_wr_data, ns_rd_data;
    logic [3:0]  ns_wr_strb;

    logic [31:0] mem [16];
    logic        mem_clr, pl_en;
    logic [3:0]  pl_idx;
    logic [31:0] pl_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(ready), .req_we_i(req_we),
        .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
        .addr_dmem_ram_o(mem_addr), .wr_data_dmem_ram_o(wr_data),
        .wr_strb_dmem_ram_o(wr_strb), .wr_en_dmem_ram_o(wr_en),
        .read_data_dmem_ram_i(rd_data)
    );

    load_store_unit #(.SPLIT_EN(1'b0)) dut_ns (
        .clk(clk), .rst(rst),
        .req_valid_i(ns_valid), .req_ready_o(ns_ready), .req_we_i(req_we),
        .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .resp_valid_o(ns_resp_valid), .resp_rdata_o(ns_resp_rdata), .resp_err_o(ns_resp_err),
        .addr_dmem_ram_o(ns_mem_addr), .wr_data_dmem_ram_o(ns_wr_data),
        .wr_strb_dmem_ram_o(ns_wr_strb), .wr_en_dmem_ram_o(ns_wr_en),
        .read_data_dmem_ram_i(ns_rd_data)
    );

    // Memory model covers 0x1000..0x103F; anything else reads as zero.
    assign rd_data    = (mem_addr[31:6] == 26'h40) ? mem[mem_addr[5:2]] : 32'd0;
    assign ns_rd_data = (ns_mem_addr[31:6] == 26'h40) ? mem[ns_mem_addr[5:2]] : 32'd0;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
        end else if (pl_en) begin
            mem[pl_idx] <= pl_data;
        end else if (wr_en && mem_addr[31:6] == 26'h40) begin
            for (int b = 0; b < 4; b++)
                if (wr_strb[b]) mem[mem_addr[5:2]][8*b +: 8] <= wr_data[8*b +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [3:0] idx, input logic [31:0] data);
        pl_en = 1'b1; pl_idx = idx; pl_data = data;
        step();
        pl_en = 1'b0;
    endtask

    task automatic run_req(input bit use_ns, input logic we, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] rd, output logic er, output int lat,
                           output logic saw_wr);
        req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        if (use_ns) ns_valid = 1'b1; else req_valid = 1'b1;
        step();
        req_valid = 1'b0; ns_valid = 1'b0;
        lat = 1;
        saw_wr = use_ns ? ns_wr_en : wr_en;
        while (!(use_ns ? ns_resp_valid : resp_valid) && lat < 8) begin
            step();
            lat++;
            saw_wr = saw_wr | (use_ns ? ns_wr_en : wr_en);
        end
        rd = use_ns ? ns_resp_rdata : resp_rdata;
        er = use_ns ? ns_resp_err : resp_err;
        step();
    endtask

    task automatic load(input string tag, input bit use_ns, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] exp_rd,
                        input logic exp_err, input int exp_lat);
        logic [31:0] rd;
        logic        er, sw;
        int          lat;
        run_req(use_ns, 1'b0, f3, a, 32'd0, rd, er, lat, sw);
        check({tag, " rdata"}, rd, exp_rd);
        check({tag, " err"}, 32'(er), 32'(exp_err));
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " wr_en"}, 32'(sw), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er, sw;
        int          lat;

        rst = 1'b1; mem_clr = 1'b1; pl_en = 1'b0; pl_idx = 4'd0; pl_data = 32'd0;
        req_valid = 1'b0; ns_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) step();
        rst = 1'b0; mem_clr = 1'b0;

        check("rst ready", 32'(ready), 32'd1);
        check("rst resp_valid", 32'(resp_valid), 32'd0);
        check("rst resp_err", 32'(resp_err), 32'd0);
        check("rst rdata", resp_rdata, 32'd0);
        check("rst wr_en", 32'(wr_en), 32'd0);
        check("rst strb", 32'(wr_strb), 32'd0);
        check("rst addr", mem_addr, 32'd0);
        check("rst wdata", wr_data, 32'd0);

        // Aligned SW
        req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h1000; req_wdata = 32'h11223344;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        check("sw acc0 addr", mem_addr, 32'h1000);
        check("sw acc0 strb", 32'(wr_strb), 32'hF);
        check("sw acc0 data", wr_data, 32'h11223344);
        check("sw acc0 wr_en", 32'(wr_en), 32'd1);
        check("sw acc0 ready", 32'(ready), 32'd0);
        check("sw acc0 no resp", 32'(resp_valid), 32'd0);
        step();
        check("sw resp_valid", 32'(resp_valid), 32'd1);
        check("sw resp_err", 32'(resp_err), 32'd0);
        check("sw resp rdata", resp_rdata, 32'd0);
        check("sw resp wr_en", 32'(wr_en), 32'd0);
        check("sw mem0", mem[0], 32'h11223344);
        step();
        check("sw back idle", 32'(ready), 32'd1);
        check("sw pulse ends", 32'(resp_valid), 32'd0);

        // Crossing SW, with a competing request held during ACC0
        req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h1002; req_wdata = 32'hDEADBEEF;
        req_valid = 1'b1;
        step();
        req_addr = 32'h1008; req_wdata = 32'h00000055;
        check("xsw acc0 ready", 32'(ready), 32'd0);
        check("xsw acc0 addr", mem_addr, 32'h1000);
        check("xsw acc0 strb", 32'(wr_strb), 32'hC);
        check("xsw acc0 data", wr_data, 32'hBEEF0000);
        check("xsw acc0 wr_en", 32'(wr_en), 32'd1);
        step();
        req_valid = 1'b0;
        check("xsw acc1 addr", mem_addr, 32'h1004);
        check("xsw acc1 strb", 32'(wr_strb), 32'h3);
        check("xsw acc1 data", wr_data, 32'h0000DEAD);
        check("xsw acc1 wr_en", 32'(wr_en), 32'd1);
        check("xsw acc1 no resp", 32'(resp_valid), 32'd0);
        step();
        check("xsw resp_valid", 32'(resp_valid), 32'd1);
        check("xsw resp_err", 32'(resp_err), 32'd0);
        check("xsw mem0", mem[0], 32'hBEEF3344);
        check("xsw mem1", mem[1], 32'h0000DEAD);
        step();
        check("xsw idle", 32'(ready), 32'd1);
        check("xsw ignored req", mem[2], 32'd0);

        // Sub-word loads with sign/zero extension
        preload(4'd0, 32'h80FF7F01);
        load("lb 1003",  1'b0, 3'd0, 32'h1003, 32'hFFFFFF80, 1'b0, 2);
        load("lbu 1003", 1'b0, 3'd4, 32'h1003, 32'h00000080, 1'b0, 2);
        load("lh 1001",  1'b0, 3'd1, 32'h1001, 32'hFFFFFF7F, 1'b0, 2);
        load("lhu 1001", 1'b0, 3'd5, 32'h1001, 32'h0000FF7F, 1'b0, 2);
        load("lb 1000",  1'b0, 3'd0, 32'h1000, 32'h00000001, 1'b0, 2);
        load("lh 1002",  1'b0, 3'd1, 32'h1002, 32'hFFFF80FF, 1'b0, 2);

        // Crossing loads, split and non-split
        preload(4'd0, 32'hAABBCCDD);
        preload(4'd1, 32'h11223344);
        load("lw 1003",     1'b0, 3'd2, 32'h1003, 32'h223344AA, 1'b0, 3);
        load("lh 1003",     1'b0, 3'd1, 32'h1003, 32'h000044AA, 1'b0, 3);
        load("lw 1004",     1'b0, 3'd2, 32'h1004, 32'h11223344, 1'b0, 2);
        load("ns lw 1003",  1'b1, 3'd2, 32'h1003, 32'h00000000, 1'b1, 1);
        load("ns lw 1004",  1'b1, 3'd2, 32'h1004, 32'h11223344, 1'b0, 2);
        load("ns lh 1002",  1'b1, 3'd1, 32'h1002, 32'hFFFFAABB, 1'b0, 2);

        // Errors and segment boundaries
        load("ld f3=3",     1'b0, 3'd3, 32'h1000, 32'h0, 1'b1, 1);
        load("lb last",     1'b0, 3'd0, 32'h00100FFF, 32'h0, 1'b0, 2);
        load("lw past end", 1'b0, 3'd2, 32'h00100FFE, 32'h0, 1'b1, 1);
        load("lw wrap",     1'b0, 3'd2, 32'hFFFFFFFE, 32'h0, 1'b1, 1);
        run_req(1'b0, 1'b1, 3'd0, 32'h0FFF, 32'h000000AB, rd, er, lat, sw);
        check("sb 0fff err", 32'(er), 32'd1);
        check("sb 0fff latency", 32'(lat), 32'd1);
        check("sb 0fff wr_en", 32'(sw), 32'd0);
        check("sb 0fff rdata", rd, 32'd0);
        run_req(1'b0, 1'b1, 3'd4, 32'h1010, 32'h12345678, rd, er, lat, sw);
        check("st f3=4 err", 32'(er), 32'd1);
        check("st f3=4 wr_en", 32'(sw), 32'd0);
        check("st f3=4 mem", mem[4], 32'd0);

        // Reset during ACC1 of a crossing store
        req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h1006; req_wdata = 32'h12345678;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        check("rsw acc0 data", wr_data, 32'h56780000);
        step();
        check("rsw acc1 wr_en", 32'(wr_en), 32'd1);
        check("rsw acc1 addr", mem_addr, 32'h1008);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid rst ready", 32'(ready), 32'd1);
        check("mid rst wr_en", 32'(wr_en), 32'd0);
        check("mid rst strb", 32'(wr_strb), 32'd0);
        check("mid rst resp", 32'(resp_valid), 32'd0);
        step();
        check("post rst resp", 32'(resp_valid), 32'd0);
        check("post rst ready", 32'(ready), 32'd1);
        load("lw after rst 1004", 1'b0, 3'd2, 32'h1004, 32'h56783344, 1'b0, 2);
        load("lw after rst 1008", 1'b0, 3'd2, 32'h1008, 32'h00001234, 1'b0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
